// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types, constants and fixed-point helpers for ray_plane_intersect
package rt_pkg;
  localparam int Q_BITS = 10;
  localparam int W      = 32;
  localparam int DW     = W + Q_BITS;
  localparam int DIVN   = DW;
  localparam int CW     = $clog2(DIVN + 1);

  typedef logic signed [W-1:0] word_t;
  typedef word_t [2:0] vec3_t;

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_DIV, S_SCALE, S_DONE} state_e;

  function automatic vec3_t vsub(vec3_t a, vec3_t b);
    vec3_t r;
    for (int i = 0; i < 3; i++) r[i] = a[i] - b[i];
    return r;
  endfunction

  function automatic logic signed [2*W-1:0] prod64(word_t a, word_t b);
    logic signed [2*W-1:0] ea, eb;
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic word_t dot3(vec3_t a, vec3_t b);
    logic signed [2*W-1:0] acc;
    acc = prod64(a[0], b[0]) + prod64(a[1], b[1]) + prod64(a[2], b[2]);
    return word_t'(acc >>> Q_BITS);
  endfunction

  function automatic word_t mulq(word_t a, word_t b);
    return word_t'(prod64(a, b) >>> Q_BITS);
  endfunction

  // -(-2^(W-1)) keeps its bit pattern, which is the correct unsigned magnitude
  function automatic logic [W-1:0] abs_w(word_t a);
    return a[W-1] ? -a : a;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle, DIVN cycles
module seq_divider
  import rt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [W-1:0]  divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o
);
  logic [DW-1:0] quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W:0]    shifted;
  logic          ge;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    shifted = {rem_q, quo_q[DW-1]};
    ge      = shifted >= {1'b0, dvs_q};
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = CW'(DIVN);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
      quo_d = {quo_q[DW-2:0], ge};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the cycle whose closing edge retires the last quotient bit
  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_q;
endmodule

// File: rtl/ray_plane_intersect.sv
// rtl/ray_plane_intersect.sv - ray/plane intersection producing p_hit for the triangle hit test
module ray_plane_intersect
  import rt_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  vec3_t origin,
  input  vec3_t dir,
  input  vec3_t normal,
  input  vec3_t v0,
  input  vec3_t v1,
  input  vec3_t v2,
  output logic  out_valid,
  input  logic  out_ready,
  output vec3_t p_hit,
  output word_t t,
  output vec3_t normal_o,
  output vec3_t v0_o,
  output vec3_t v1_o,
  output vec3_t v2_o,
  output logic  plane_hit,
  output logic  overflow
);
  state_e state_q, state_d;
  vec3_t  origin_q, dir_q, normal_q, v0_q, v1_q, v2_q, p_hit_q, p_c;
  word_t  t_q, num_c, den_c, t_c;
  logic   num_neg_q, den_neg_q, den_zero_q, hit_q, ovf_q;
  logic   neg_c, ovf_c, hit_c;
  logic   div_start, div_busy, div_done;
  logic [DW-1:0] quo;

  assign in_ready  = (state_q == S_IDLE) && !div_busy;
  assign out_valid = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    unique case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_DOT;
      S_DOT:   begin div_start = 1'b1; state_d = S_DIV; end
      S_DIV:   if (div_done) state_d = S_SCALE;
      S_SCALE: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    num_c = dot3(normal_q, vsub(v0_q, origin_q));
    den_c = dot3(normal_q, dir_q);
    neg_c = num_neg_q ^ den_neg_q;
    // with den==0 the quotient is garbage; den_zero_q forces the miss and masks overflow
    ovf_c = !den_zero_q && (quo[DW-1:W-1] != '0);
    t_c   = neg_c ? -quo[W-1:0] : quo[W-1:0];
    hit_c = !den_zero_q && !ovf_c && !t_c[W-1] && (t_c != '0);
    p_c   = '0;
    for (int i = 0; i < 3; i++) p_c[i] = origin_q[i] + mulq(t_c, dir_q[i]);
  end

  seq_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i ({abs_w(num_c), {Q_BITS{1'b0}}}),
    .divisor_i  (abs_w(den_c)),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      origin_q   <= '0;
      dir_q      <= '0;
      normal_q   <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      num_neg_q  <= 1'b0;
      den_neg_q  <= 1'b0;
      den_zero_q <= 1'b0;
      t_q        <= '0;
      p_hit_q    <= '0;
      hit_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_valid && in_ready) begin
        origin_q <= origin;
        dir_q    <= dir;
        normal_q <= normal;
        v0_q     <= v0;
        v1_q     <= v1;
        v2_q     <= v2;
      end
      if (state_q == S_DOT) begin
        num_neg_q  <= num_c[W-1];
        den_neg_q  <= den_c[W-1];
        den_zero_q <= (den_c == '0);
      end
      if (state_q == S_SCALE) begin
        t_q     <= hit_c ? t_c : '0;
        p_hit_q <= hit_c ? p_c : '0;
        hit_q   <= hit_c;
        ovf_q   <= ovf_c;
      end
    end
  end

  assign p_hit     = p_hit_q;
  assign t         = t_q;
  assign normal_o  = normal_q;
  assign v0_o      = v0_q;
  assign v1_o      = v1_q;
  assign v2_o      = v2_q;
  assign plane_hit = hit_q;
  assign overflow  = ovf_q;
endmodule
